// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and memory-stage state encoding
package cpu_pkg;

  localparam int WORD_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - wait-cycle counter for the memory request (built under MEM_TIMEOUT_EN)
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires on the last unacknowledged cycle, so the request stays up exactly TIMEOUT_CYCLES cycles.
  assign expired = inc && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage with stalling data-memory handshake; MEM_TIMEOUT_EN adds request timeout
module mem_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic [WORD_W-1:0] ALUResult_i,
  input  logic [WORD_W-1:0] WriteData_i,
  input  logic [REG_AW-1:0] RDaddr_i,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [WORD_W-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [WORD_W-1:0] mem_rdata_i,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [WORD_W-1:0] ALUResult_o,
  output logic [WORD_W-1:0] ReadData_o,
  output logic [REG_AW-1:0] RDaddr_o,
  output logic              err_o,
  output logic              timeout_o
);

  mem_state_e        state;
  logic              lat_we;
  logic              lat_regwrite;
  logic              lat_memtoreg;
  logic [WORD_W-1:0] lat_alu;
  logic [WORD_W-1:0] lat_wdata;
  logic [REG_AW-1:0] lat_rd;
  logic [WORD_W-1:0] rdata_q;
  logic              timed_out_q;

  logic any_op;
  logic bad_op;
  logic accept;
  logic tmo_expired;

  assign any_op = MemRead_i | MemWrite_i;
  assign bad_op = any_op && ((MemRead_i && MemWrite_i) || (ALUResult_i[1:0] != 2'b00));
  assign accept = (state == ST_IDLE) && any_op && !bad_op;

`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  (state != ST_REQ),
    .inc    ((state == ST_REQ) && !mem_ack_i),
    .expired(tmo_expired)
  );
  assign timeout_o = (state == ST_DONE) && timed_out_q;
`else
  assign tmo_expired = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      lat_we       <= 1'b0;
      lat_regwrite <= 1'b0;
      lat_memtoreg <= 1'b0;
      lat_alu      <= '0;
      lat_wdata    <= '0;
      lat_rd       <= '0;
      rdata_q      <= '0;
      timed_out_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_we       <= MemWrite_i;
            lat_regwrite <= RegWrite_i;
            lat_memtoreg <= MemtoReg_i;
            lat_alu      <= ALUResult_i;
            lat_wdata    <= WriteData_i;
            lat_rd       <= RDaddr_i;
            timed_out_q  <= 1'b0;
            state        <= ST_REQ;
          end
        end
        ST_REQ: begin
          // An ack arriving on the timeout cycle still completes the access.
          if (mem_ack_i) begin
            rdata_q <= lat_we ? '0 : mem_rdata_i;
            state   <= ST_DONE;
          end else if (tmo_expired) begin
            rdata_q     <= '0;
            timed_out_q <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = lat_alu;
    mem_wdata_o = lat_wdata;
    err_o       = 1'b0;
    RegWrite_o  = RegWrite_i;
    MemtoReg_o  = MemtoReg_i;
    ALUResult_o = ALUResult_i;
    ReadData_o  = '0;
    RDaddr_o    = RDaddr_i;
    case (state)
      ST_REQ: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = lat_we;
        RegWrite_o  = 1'b0;
        MemtoReg_o  = lat_memtoreg;
        ALUResult_o = lat_alu;
        RDaddr_o    = lat_rd;
      end
      ST_DONE: begin
        RegWrite_o  = lat_regwrite && !timed_out_q;
        MemtoReg_o  = lat_memtoreg;
        ALUResult_o = lat_alu;
        ReadData_o  = rdata_q;
        RDaddr_o    = lat_rd;
      end
      default: begin
        if (bad_op) begin
          err_o      = 1'b1;
          RegWrite_o = 1'b0;
        end else if (accept) begin
          // Keep the writeback register from committing a half-done memory op.
          stall_o    = 1'b1;
          RegWrite_o = 1'b0;
        end
      end
    endcase
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, maximum cycles waiting for mem_ack_i (used only under MEM_TIMEOUT_EN).
REQ-002 SHALL have one clock and synchronous active-high reset; ports listed clock and reset first:
- clk_i  input  1  rising-edge clock
- rst_i  input  1  synchronous active-high reset
- MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i  input  1 each  control from EX/MEM register
- ALUResult_i  input  32  ALU result; byte address for memory ops
- WriteData_i  input  32  store data
- RDaddr_i  input  5  destination register
- stall_o  output  1  holds PC/IF/ID/EX/MEM registers while high
- mem_req_o, mem_we_o  output  1 each  data-memory request, write enable
- mem_addr_o, mem_wdata_o  output  32 each  memory address, write data
- mem_ack_i  input  1  memory completion
- mem_rdata_i  input  32  read data, valid with mem_ack_i
- RegWrite_o, MemtoReg_o  output  1 each  to MEM/WB register
- ALUResult_o, ReadData_o  output  32 each  to MEM/WB register
- RDaddr_o  output  5  to MEM/WB register
- err_o  output  1  one-cycle pulse: misaligned or illegal access
- timeout_o  output  1  one-cycle pulse: access abandoned

Function
REQ-003 SHALL implement FSM states IDLE, REQ, DONE.
REQ-004 IDLE, MemRead_i=MemWrite_i=0: outputs pass inputs combinationally, ReadData_o=0, stall_o=0, stay IDLE.
REQ-005 IDLE, exactly one of MemRead_i/MemWrite_i set, ALUResult_i[1:0]=0: stall_o=1 same cycle; latch all inputs; next state REQ.
REQ-006 REQ: mem_req_o=1, mem_we_o=latched MemWrite, mem_addr_o/mem_wdata_o=latched values held stable; stall_o=1; RegWrite_o=0.
REQ-007 REQ with mem_ack_i=1: capture mem_rdata_i (read) or 0 (write); next state DONE; ack SHALL be accepted in first REQ cycle.
REQ-008 DONE: stall_o=0, mem_req_o=0; outputs from latched copy, ReadData_o=captured data; next state IDLE (one cycle, inputs ignored).
REQ-009 Minimum memory-op latency: accept cycle 0, REQ cycle 1, DONE cycle 2; stall_o high exactly cycles 0..1+wait.
REQ-010 Misaligned (ALUResult_i[1:0]!=0) or MemRead_i=MemWrite_i=1 in IDLE: no request, no stall, err_o=1 for that cycle, RegWrite_o=0, other outputs pass through.
REQ-011 mem_ack_i outside REQ SHALL be ignored.
REQ-012 mem_req_o SHALL never be asserted in IDLE or DONE.

Reset
REQ-013 rst_i high at clock edge: state IDLE, latched registers 0, timeout counter 0, regardless of current state.
REQ-014 After reset: stall_o=0, mem_req_o=0, mem_we_o=0, err_o=0, timeout_o=0; other outputs follow REQ-004.
REQ-015 Reset during REQ SHALL drop mem_req_o the cycle after the reset edge; pending ack discarded.

Configuration
REQ-016 Macro MEM_TIMEOUT_EN defined: counter increments each REQ cycle without ack; at TIMEOUT_CYCLES, drop mem_req_o, go DONE with ReadData_o=0, RegWrite_o=0, timeout_o=1 for one cycle.
REQ-017 MEM_TIMEOUT_EN undefined: REQ waits indefinitely, timeout_o tied 0, no counter logic.
REQ-018 Ack and timeout in same cycle: ack wins.

Structure
REQ-019 Shared package cpu_pkg SHALL hold state enum, word width 32, register address width 5.
REQ-020 Optional sub-module mem_timeout_ctr SHALL hold the counter, instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-021 ALU op, RegWrite_i=1, ALUResult_i=0x10, RDaddr_i=3 -> same-cycle outputs pass, stall_o=0, no mem_req_o.
REQ-022 Load addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF -> stall_o high 4 cycles, DONE shows ReadData_o=0xDEADBEEF, RegWrite_o=1.
REQ-023 Store addr 0x204, data 0x12345678, ack in first REQ cycle -> mem_we_o=1, mem_wdata_o=0x12345678, stall_o high 2 cycles.
REQ-024 Load addr 0x102 -> err_o pulse, RegWrite_o=0, mem_req_o never high, stall_o=0.
REQ-025 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_req_o high 4 cycles, timeout_o pulse, RegWrite_o=0.
REQ-026 rst_i asserted in second REQ cycle, ack next cycle -> state IDLE, mem_req_o=0, stall_o=0, ack ignored.
